o_timing_tracker: RTL and testbench

//  Parametrised successor of the scope-side pixel counter. Recovers X/Y position from the

---
 rtl/o_timing_if.sv | 32 +++
 rtl/o_timing_tracker.sv | 234 +++++++++++++++++++++++
 tb/tb_o_timing_tracker.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/o_timing_if.sv
// Scope-side sync inputs and tracker results between capture pins and frame-buffer writer.
// slave = tracker side, master = scope/capture side.
interface o_timing_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9
);
  logic          ENABLE;
  logic          O_HS;
  logic          O_VS;
  logic [XW-1:0] O_X;
  logic [YW-1:0] O_Y;
  logic          O_VISIBLE;
  logic          LOCKED;
  logic [11:0]   H_MEAS;
  logic [10:0]   V_MEAS;
  logic          HS_POL_DET;
  logic          VS_POL_DET;
  logic          PULSE;
  logic          SYNC;

  modport master (
    output ENABLE, O_HS, O_VS,
    input  O_X, O_Y, O_VISIBLE, LOCKED, H_MEAS, V_MEAS,
           HS_POL_DET, VS_POL_DET, PULSE, SYNC
  );

  modport slave (
    input  ENABLE, O_HS, O_VS,
    output O_X, O_Y, O_VISIBLE, LOCKED, H_MEAS, V_MEAS,
           HS_POL_DET, VS_POL_DET, PULSE, SYNC
  );
endinterface

// File: rtl/o_timing_tracker.sv
// Recovers scope X/Y from HS/VS, measures line/frame timing and qualifies O_VISIBLE with a lock FSM.
// Optional automatic sync polarity detection: define O_TIMING_AUTOPOL_EN.
module o_timing_tracker #(
  parameter int unsigned XW                = 10,
  parameter int unsigned YW                = 9,
  parameter int unsigned H_FRONT_PORCH     = 136,
  parameter int unsigned H_VISIBLE         = 576,
  parameter int unsigned H_TOTAL           = 800,
  parameter int unsigned V_FRONT_PORCH     = 25,
  parameter int unsigned V_VISIBLE         = 378,
  parameter int unsigned V_TOTAL           = 417,
  parameter int unsigned H_TOL             = 2,
  parameter int unsigned V_TOL             = 1,
  parameter int unsigned LOCK_FRAMES       = 3,
  parameter bit          HS_POL            = 1'b0,
  parameter bit          VS_POL            = 1'b0,
  parameter int unsigned FRAMES_PER_TOGGLE = 60,
  parameter int unsigned SYNC_LINE         = 12
) (
  input logic       O_CLK,
  input logic       RESET_N,
  o_timing_if.slave bus
);

  localparam int unsigned HMW = 12;
  localparam int unsigned VMW = 11;
  localparam int unsigned FCW = 24;
  localparam int unsigned GCW = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned PCW = (FRAMES_PER_TOGGLE > 2) ? $clog2(FRAMES_PER_TOGGLE) : 1;

  localparam logic [HMW-1:0] H_LO = HMW'(H_TOTAL - H_TOL);
  localparam logic [HMW-1:0] H_HI = HMW'(H_TOTAL + H_TOL);
  localparam logic [VMW-1:0] V_LO = VMW'(V_TOTAL - V_TOL);
  localparam logic [VMW-1:0] V_HI = VMW'(V_TOTAL + V_TOL);
  localparam logic [FCW-1:0] TIMEOUT_M1 = FCW'(4 * H_TOTAL * V_TOTAL - 1);

  typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOCKED} state_e;

  state_e         state, state_nxt;
  logic [GCW-1:0] good_cnt, good_nxt;
  logic           locked;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [HMW-1:0] h_cnt, h_meas, h_inc, h_judge;
  logic [VMW-1:0] v_cnt, v_meas, v_new;
  logic [FCW-1:0] frm_cnt;
  logic [PCW-1:0] fcnt;
  logic           pulse;
  logic           hs_prev, vs_prev;
  logic           hs_pol, vs_pol;
  logic           pol_chg;
  logic           hs_act, vs_act, hs_edge, vs_edge;
  logic           frame_good;

  // Raw sync history; runs regardless of ENABLE so re-enabling never sees a stale edge
  always_ff @(posedge O_CLK) begin
    if (!RESET_N) begin
      hs_prev <= ~HS_POL;
      vs_prev <= ~VS_POL;
    end else begin
      hs_prev <= bus.O_HS;
      vs_prev <= bus.O_VS;
    end
  end

`ifdef O_TIMING_AUTOPOL_EN
  localparam int unsigned PTW = 20;
  logic [PTW-1:0] hs_tmr, hs_tmr_inc, hs_len0, hs_len1;
  logic [PTW-1:0] vs_tmr, vs_tmr_inc, vs_len0, vs_len1;
  logic           hs_pol_nxt, vs_pol_nxt;

  // Active level is the one with the shorter measured phase; wait until both phases are known
  always_comb begin
    hs_tmr_inc = (hs_tmr == '1) ? hs_tmr : hs_tmr + PTW'(1);
    vs_tmr_inc = (vs_tmr == '1) ? vs_tmr : vs_tmr + PTW'(1);
    hs_pol_nxt = hs_pol;
    vs_pol_nxt = vs_pol;
    if (hs_len0 != '0 && hs_len1 != '0) begin
      if (hs_len0 < hs_len1)      hs_pol_nxt = 1'b0;
      else if (hs_len1 < hs_len0) hs_pol_nxt = 1'b1;
    end
    if (vs_len0 != '0 && vs_len1 != '0) begin
      if (vs_len0 < vs_len1)      vs_pol_nxt = 1'b0;
      else if (vs_len1 < vs_len0) vs_pol_nxt = 1'b1;
    end
    pol_chg = bus.ENABLE && ((hs_pol_nxt != hs_pol) || (vs_pol_nxt != vs_pol));
  end

  always_ff @(posedge O_CLK) begin
    if (!RESET_N) begin
      hs_tmr  <= '0;
      hs_len0 <= '0;
      hs_len1 <= '0;
      vs_tmr  <= '0;
      vs_len0 <= '0;
      vs_len1 <= '0;
      hs_pol  <= HS_POL;
      vs_pol  <= VS_POL;
    end else if (bus.ENABLE) begin
      if (bus.O_HS != hs_prev) begin
        if (hs_prev) hs_len1 <= hs_tmr_inc;
        else         hs_len0 <= hs_tmr_inc;
        hs_tmr <= '0;
      end else begin
        hs_tmr <= hs_tmr_inc;
      end
      if (bus.O_VS != vs_prev) begin
        if (vs_prev) vs_len1 <= vs_tmr_inc;
        else         vs_len0 <= vs_tmr_inc;
        vs_tmr <= '0;
      end else begin
        vs_tmr <= vs_tmr_inc;
      end
      hs_pol <= hs_pol_nxt;
      vs_pol <= vs_pol_nxt;
    end
  end
`else
  assign hs_pol  = HS_POL;
  assign vs_pol  = VS_POL;
  assign pol_chg = 1'b0;
`endif

  // Edge detection and frame qualification against nominal totals
  always_comb begin
    hs_act     = (bus.O_HS == hs_pol);
    vs_act     = (bus.O_VS == vs_pol);
    hs_edge    = hs_act && (hs_prev != hs_pol);
    vs_edge    = vs_act && (vs_prev != vs_pol);
    h_inc      = (h_cnt == '1) ? h_cnt : h_cnt + HMW'(1);
    v_new      = (hs_edge && v_cnt != '1) ? v_cnt + VMW'(1) : v_cnt;
    h_judge    = hs_edge ? h_inc : h_meas;
    frame_good = (h_judge >= H_LO) && (h_judge <= H_HI) && (v_new >= V_LO) && (v_new <= V_HI);
  end

  // Lock FSM next state; a VS edge takes priority over the frame timeout
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    if (bus.ENABLE) begin
      if (pol_chg || (!vs_edge && frm_cnt >= TIMEOUT_M1)) begin
        state_nxt = S_SEARCH;
        good_nxt  = '0;
      end else if (vs_edge) begin
        case (state)
          S_SEARCH: begin
            state_nxt = S_TRACK;
            good_nxt  = '0;
          end
          S_TRACK: begin
            if (!frame_good) begin
              good_nxt = '0;
            end else if (good_cnt >= GCW'(LOCK_FRAMES - 1)) begin
              state_nxt = S_LOCKED;
              good_nxt  = '0;
            end else begin
              good_nxt = good_cnt + GCW'(1);
            end
          end
          S_LOCKED: begin
            if (!frame_good) begin
              state_nxt = S_TRACK;
              good_nxt  = '0;
            end
          end
          default: begin
            state_nxt = S_SEARCH;
            good_nxt  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge O_CLK) begin
    if (!RESET_N) begin
      state    <= S_SEARCH;
      good_cnt <= '0;
      locked   <= 1'b0;
      x        <= '0;
      y        <= '0;
      h_cnt    <= '0;
      h_meas   <= '0;
      v_cnt    <= '0;
      v_meas   <= '0;
      frm_cnt  <= '0;
      fcnt     <= '0;
      pulse    <= 1'b0;
    end else if (bus.ENABLE) begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      locked   <= (state_nxt == S_LOCKED);
      if (hs_act)         x <= '0;
      else if (x != '1)   x <= x + XW'(1);
      if (vs_act)                  y <= '0;
      else if (hs_edge && y != '1) y <= y + YW'(1);
      if (hs_edge) begin
        h_meas <= h_inc;
        h_cnt  <= '0;
      end else begin
        h_cnt  <= h_inc;
      end
      if (vs_edge) begin
        v_meas  <= v_new;
        v_cnt   <= '0;
        frm_cnt <= '0;
        if (fcnt == PCW'(FRAMES_PER_TOGGLE - 1)) begin
          fcnt  <= '0;
          pulse <= ~pulse;
        end else begin
          fcnt  <= fcnt + PCW'(1);
        end
      end else begin
        v_cnt   <= v_new;
        if (frm_cnt != '1) frm_cnt <= frm_cnt + FCW'(1);
      end
    end
  end

  // Position relative to the visible window; combinational from the X/Y registers
  assign bus.O_X        = x - XW'(H_FRONT_PORCH);
  assign bus.O_Y        = y - YW'(V_FRONT_PORCH);
  assign bus.O_VISIBLE  = bus.ENABLE && locked &&
                          (x >= XW'(H_FRONT_PORCH)) && (x < XW'(H_FRONT_PORCH + H_VISIBLE)) &&
                          (y >= YW'(V_FRONT_PORCH)) && (y < YW'(V_FRONT_PORCH + V_VISIBLE));
  assign bus.SYNC       = (y == YW'(SYNC_LINE));
  assign bus.LOCKED     = locked;
  assign bus.H_MEAS     = h_meas;
  assign bus.V_MEAS     = v_meas;
  assign bus.PULSE      = pulse;
  assign bus.HS_POL_DET = hs_pol;
  assign bus.VS_POL_DET = vs_pol;

endmodule

// File: tb/tb_o_timing_tracker.sv
// Scoreboard bench for o_timing_tracker on a scaled 40x20 raster (active-low syncs).
// Stimulus schedules expected values by cycle; a negedge monitor pops and compares them.
module tb_o_timing_tracker;

  localparam int unsigned HF  = 8;
  localparam int unsigned HV  = 24;
  localparam int unsigned HT  = 40;
  localparam int unsigned VF  = 3;
  localparam int unsigned VV  = 12;
  localparam int unsigned VT  = 20;
  localparam int unsigned FPT = 4;
  localparam int unsigned SL  = 2;
  localparam int unsigned FR  = HT * VT;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  o_timing_if #(.XW(10), .YW(9)) bus ();

  o_timing_tracker #(
    .XW(10), .YW(9),
    .H_FRONT_PORCH(HF), .H_VISIBLE(HV), .H_TOTAL(HT),
    .V_FRONT_PORCH(VF), .V_VISIBLE(VV), .V_TOTAL(VT),
    .H_TOL(2), .V_TOL(1), .LOCK_FRAMES(3),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .FRAMES_PER_TOGGLE(FPT), .SYNC_LINE(SL)
  ) dut (
    .O_CLK  (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  typedef enum int {S_OX, S_OY, S_VIS, S_LOCK, S_HM, S_VM, S_PULSE, S_SYNC} sig_e;
  typedef struct {
    int unsigned cyc;
    sig_e        sig;
    int unsigned val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc   = 0;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned actual(input sig_e s);
    case (s)
      S_OX:    return 32'(bus.O_X);
      S_OY:    return 32'(bus.O_Y);
      S_VIS:   return 32'(bus.O_VISIBLE);
      S_LOCK:  return 32'(bus.LOCKED);
      S_HM:    return 32'(bus.H_MEAS);
      S_VM:    return 32'(bus.V_MEAS);
      S_PULSE: return 32'(bus.PULSE);
      S_SYNC:  return 32'(bus.SYNC);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic expect_at(input int unsigned off, input sig_e s, input int unsigned v,
                           input string nm);
    exp_t e;
    e.cyc  = cyc + off;
    e.sig  = s;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due this cycle
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.cyc != cyc) begin
        n_err++;
        $display("FAIL %s: due at cycle %0d, seen only at cycle %0d", e.name, e.cyc, cyc);
      end else if (actual(e.sig) != e.val) begin
        n_err++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, actual(e.sig), e.val, cyc);
      end
    end
  end

  task automatic tick(input logic hs, input logic vs);
    bus.O_HS = hs;
    bus.O_VS = vs;
    @(posedge clk);
    #1;
  endtask

  // One frame: HS low on the first cycle of each line, VS low for the whole first line
  task automatic frame(input int unsigned lines);
    for (int l = 0; l < int'(lines); l++)
      for (int c = 0; c < int'(HT); c++)
        tick((c == 0) ? 1'b0 : 1'b1, (l == 0) ? 1'b0 : 1'b1);
  endtask

  // Four ideal frames from SEARCH: lock one cycle after the 4th VS edge, PULSE toggles there
  task automatic lock_seq(input string tag);
    expect_at(FR + 1,          S_HM,    40, {tag, "_h_meas"});
    expect_at(2*FR + 5*HT + 1, S_VM,    20, {tag, "_v_meas"});
    expect_at(2*FR + 5*HT + 1, S_HM,    40, {tag, "_h_meas_f2"});
    expect_at(3*FR,            S_LOCK,  0,  {tag, "_locked_before_4th"});
    expect_at(3*FR,            S_PULSE, 0,  {tag, "_pulse_before_4th"});
    expect_at(3*FR + 1,        S_LOCK,  1,  {tag, "_locked_after_4th"});
    expect_at(3*FR + 1,        S_PULSE, 1,  {tag, "_pulse_at_4th"});
    repeat (4) frame(VT);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.ENABLE = 1'b1;
    bus.O_HS   = 1'b1;
    bus.O_VS   = 1'b1;
    @(posedge clk);
    #1;

    // Reset with toggling syncs
    expect_at(5, S_OX,    1016, "rst_o_x");
    expect_at(5, S_OY,    509,  "rst_o_y");
    expect_at(5, S_LOCK,  0,    "rst_locked");
    expect_at(5, S_PULSE, 0,    "rst_pulse");
    expect_at(5, S_VIS,   0,    "rst_visible");
    expect_at(5, S_HM,    0,    "rst_h_meas");
    expect_at(5, S_VM,    0,    "rst_v_meas");
    for (int i = 0; i < 5; i++) tick(1'(i), 1'(i >> 1));
    rst_n = 1'b1;
    repeat (3) tick(1'b1, 1'b1);

    lock_seq("lock1");

    // Window, modulo offsets and SYNC line inside a locked frame
    expect_at(2*HT + 6,  S_SYNC, 1,    "sync_line");
    expect_at(3*HT + 1,  S_OX,   1016, "o_x_wrap");
    expect_at(3*HT + 1,  S_VIS,  0,    "vis_x0");
    expect_at(3*HT + 9,  S_OX,   0,    "o_x_origin");
    expect_at(3*HT + 9,  S_OY,   0,    "o_y_origin");
    expect_at(3*HT + 9,  S_VIS,  1,    "vis_origin");
    expect_at(3*HT + 9,  S_SYNC, 0,    "sync_off");
    expect_at(3*HT + 33, S_VIS,  0,    "vis_x_end");
    expect_at(3*HT + 33, S_OX,   24,   "o_x_end");
    expect_at(14*HT + 11, S_VIS, 1,    "vis_last_line");
    expect_at(14*HT + 11, S_OY,  11,   "o_y_last_line");
    expect_at(15*HT + 11, S_VIS, 0,    "vis_y_end");
    expect_at(15*HT + 11, S_OY,  12,   "o_y_end");
    frame(VT);

    // Short-by-one frame is within tolerance
    expect_at(1, S_LOCK, 1, "locked_after_good");
    frame(VT - 1);
    expect_at(1, S_LOCK, 1,  "locked_after_19_lines");
    expect_at(2, S_VM,   19, "v_meas_19");
    frame(VT);

    // Three lines short drops lock; three good frames relock
    expect_at(1,      S_PULSE, 0,  "pulse_at_8th");
    expect_at(17*HT,  S_LOCK,  1,  "locked_before_bad");
    expect_at(17*HT + 1, S_LOCK, 0, "unlocked_after_bad");
    expect_at(17*HT + 2, S_VM, 17, "v_meas_17");
    frame(VT - 3);
    expect_at(3*FR,     S_LOCK,  0, "relock_not_yet");
    expect_at(3*FR + 1, S_LOCK,  1, "relock");
    expect_at(3*FR + 1, S_PULSE, 1, "pulse_at_12th");
    repeat (4) frame(VT);

    // ENABLE low holds X/Y while history keeps tracking HS
    expect_at(1, S_OX, 31, "hold_o_x");
    expect_at(3, S_OX, 31, "hold_o_x_3");
    expect_at(3, S_OY, 16, "hold_o_y");
    bus.ENABLE = 1'b0;
    repeat (3) tick(1'b0, 1'b1);
    bus.ENABLE = 1'b1;
    expect_at(1, S_OX,   1016, "reenable_o_x");
    expect_at(1, S_OY,   16,   "reenable_no_false_edge");
    expect_at(2, S_OX,   1017, "reenable_count");
    expect_at(2, S_LOCK, 1,    "reenable_locked");
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);

    // VS stops: 801 enabled cycles already elapsed since last VS edge, timeout at 3200
    expect_at(2398, S_LOCK, 1,    "timeout_not_yet");
    expect_at(2399, S_LOCK, 0,    "timeout_search");
    expect_at(2399, S_OX,   1015, "x_saturated");
    expect_at(2399, S_OY,   16,   "y_held");
    repeat (2399) tick(1'b1, 1'b1);

    // Mid-run reset, then full relock
    rst_n = 1'b0;
    expect_at(2, S_LOCK,  0,    "rst2_locked");
    expect_at(2, S_PULSE, 0,    "rst2_pulse");
    expect_at(2, S_HM,    0,    "rst2_h_meas");
    expect_at(2, S_VM,    0,    "rst2_v_meas");
    expect_at(2, S_OX,    1016, "rst2_o_x");
    repeat (2) tick(1'b1, 1'b1);
    rst_n = 1'b1;
    repeat (2) tick(1'b1, 1'b1);
    lock_seq("lock2");

    repeat (3) tick(1'b1, 1'b1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      n_err++;
      $display("FAIL %s: never compared (due cycle %0d)", e.name, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
